l1_cache: RTL and testbench

- Direct-mapped, write-through, write-allocate cache.
- Sits between the LC-3b CPU memory port (the control FSM's mem_read/mem_write/mem_byte_enable/mem_resp handshake) and the 128-bit-line physical memory.
- Serves 16-bit word reads and byte-masked writes from resident 16-byte lines.
- Fills a line from physical memory on a miss; every write is pushed through to physical memory as a full line.

---
 rtl/l1_cache.sv | 132 +++++++++++++
 tb/tb_l1_cache.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache.sv
// Direct-mapped, write-through, write-allocate L1 cache between the LC-3b memory port and 128-bit physical memory.
// Optional hit/miss counters are included when CACHE_STATS_EN is defined.
module l1_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;

  typedef enum logic [1:0] {IDLE, FILL, WRITE_THRU} state_t;

  state_t state, next_state;

  logic [127:0]        data_arr [NUM_SETS];
  logic [TW-1:0]       tag_arr  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_arr;

  logic [IW-1:0] index;
  logic [TW-1:0] tag;
  logic [2:0]    word;
  logic [127:0]  line;
  logic [127:0]  merged_line;
  logic          hit;
  logic          unused_addr_bit;

  assign index           = mem_address[3+IW:4];
  assign tag             = mem_address[15:4+IW];
  assign word            = mem_address[3:1];
  assign unused_addr_bit = mem_address[0];
  assign line            = data_arr[index];
  assign hit             = valid_arr[index] && (tag_arr[index] == tag);

  always_comb begin
    merged_line = line;
    if (mem_byte_enable[0]) merged_line[{word, 4'b0000} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_line[{word, 4'b1000} +: 8] = mem_wdata[15:8];
  end

  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {tag, index, 4'b0000};
    pmem_wdata   = line;
    case (state)
      IDLE: begin
        // A write wins over a simultaneous read.
        if (mem_write) begin
          next_state = hit ? WRITE_THRU : FILL;
        end else if (mem_read) begin
          if (hit) begin
            mem_resp  = 1'b1;
            mem_rdata = line[{word, 4'b0000} +: 16];
          end else begin
            next_state = FILL;
          end
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) next_state = IDLE;
      end
      WRITE_THRU: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          mem_resp   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid_arr <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && mem_write && hit) data_arr[index] <= merged_line;
      if (state == FILL && pmem_resp) begin
        data_arr[index]  <= pmem_rdata;
        tag_arr[index]   <= tag;
        valid_arr[index] <= 1'b1;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic after_fill;
  logic hit_lookup;

  // The hit right after a fill belongs to the request already counted as a miss.
  assign hit_lookup = (state == IDLE) && (mem_read || mem_write) && hit && !after_fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      after_fill <= 1'b0;
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      after_fill <= (state == FILL) && pmem_resp;
      if (hit_lookup) hit_count <= hit_count + 16'd1;
      if (state == IDLE && next_state == FILL) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Directed, table-driven bench for l1_cache with a fixed-latency physical memory model.
// Counter checks are compiled in when CACHE_STATS_EN is defined.
module tb_l1_cache;

  localparam int NS  = 8;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
`ifdef CACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_cache #(.NUM_SETS(NS)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
`ifdef CACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  // Physical memory: answers in the LAT-th cycle a request is seen; unknown lines hold their own address.
  logic [127:0] pmem_store [logic [15:0]];
  int pcount = 0;

  always @(negedge clk) begin
    if (pmem_read || pmem_write) begin
      pcount++;
      if (pcount == LAT) begin
        pmem_resp = 1'b1;
        pcount    = 0;
        if (pmem_write) pmem_store[pmem_address] = pmem_wdata;
        else pmem_rdata = pmem_store.exists(pmem_address) ? pmem_store[pmem_address] : {8{pmem_address}};
      end else begin
        pmem_resp = 1'b0;
      end
    end else begin
      pmem_resp = 1'b0;
      pcount    = 0;
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          cycles;
    logic [15:0] rdata;
    logic        pread;
    logic        pwrite;
    logic [15:0] paddr;
    logic [15:0] pword;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rd, input logic wr, input logic [15:0] addr, input logic [1:0] be,
                        input logic [15:0] wdata, input int cycles, input logic [15:0] rdata,
                        input logic pread, input logic pwrite, input logic [15:0] paddr,
                        input logic [15:0] pword);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata;
    v.cycles = cycles; v.rdata = rdata; v.pread = pread; v.pwrite = pwrite;
    v.paddr = paddr; v.pword = pword;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one CPU request, watches every cycle until mem_resp (bounded), then idles one cycle.
  task automatic applyStimulus(input vec_t v, output int cyc, output logic [15:0] rdata,
                               output logic saw_rd, output logic saw_wr, output logic [15:0] paddr,
                               output logic [127:0] pline, output logic both);
    logic got;
    got = 1'b0; cyc = 0; rdata = '0; saw_rd = 1'b0; saw_wr = 1'b0;
    paddr = '0; pline = '0; both = 1'b0;
    mem_address = v.addr; mem_read = v.rd; mem_write = v.wr;
    mem_byte_enable = v.be; mem_wdata = v.wdata;
    while (!got && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
      if (pmem_read)  begin saw_rd = 1'b1; paddr = pmem_address; end
      if (pmem_write) begin saw_wr = 1'b1; paddr = pmem_address; pline = pmem_wdata; end
      if (pmem_read && pmem_write) both = 1'b1;
      if (mem_resp) begin got = 1'b1; rdata = mem_rdata; end
    end
    if (!got) cyc = -1;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic resetDuringFill();
    mem_address = 16'h2340; mem_read = 1'b1; mem_write = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("fill_pmem_read", 32'(pmem_read), 32'd1);
    checkOutput("fill_paddr", 32'(pmem_address), 32'h2340);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    checkOutput("rst_fill_pmem_read", 32'(pmem_read), 32'd0);
    checkOutput("rst_fill_mem_resp", 32'(mem_resp), 32'd0);
    checkOutput("rst_fill_mem_rdata", 32'(mem_rdata), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int          cyc;
    logic [15:0] rdata;
    logic        saw_rd;
    logic        saw_wr;
    logic [15:0] paddr;
    logic [127:0] pline;
    logic        both;
    logic [2:0]  w;

    pmem_store[16'h1230] = 128'h7777_6666_5555_4444_CAFE_BEEF_2222_1111;
    pmem_store[16'h0010] = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
    pmem_store[16'h0090] = 128'h0097_0096_0095_0094_0093_0092_0091_0090;

    //     rd    wr    addr      be     wdata     cyc rdata     prd   pwr   paddr     pword
    addVec(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, 5, 16'hBEEF, 1'b1, 1'b0, 16'h1230, 16'h0000);
    addVec(1'b1, 1'b0, 16'h1236, 2'b00, 16'h0000, 1, 16'hCAFE, 1'b0, 1'b0, 16'h0000, 16'h0000);
    addVec(1'b0, 1'b1, 16'h1234, 2'b10, 16'hAA55, 4, 16'h0000, 1'b0, 1'b1, 16'h1230, 16'hAAEF);
    addVec(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, 1, 16'hAAEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    addVec(1'b1, 1'b0, 16'h1235, 2'b00, 16'h0000, 1, 16'hAAEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    addVec(1'b0, 1'b1, 16'h1236, 2'b01, 16'h1234, 4, 16'h0000, 1'b0, 1'b1, 16'h1230, 16'hCA34);
    addVec(1'b0, 1'b1, 16'h1232, 2'b00, 16'hFFFF, 4, 16'h0000, 1'b0, 1'b1, 16'h1230, 16'h2222);
    addVec(1'b1, 1'b0, 16'h1236, 2'b00, 16'h0000, 1, 16'hCA34, 1'b0, 1'b0, 16'h0000, 16'h0000);
    addVec(1'b1, 1'b1, 16'h1230, 2'b11, 16'h0F0F, 4, 16'h0000, 1'b0, 1'b1, 16'h1230, 16'h0F0F);
    addVec(1'b1, 1'b0, 16'h1230, 2'b00, 16'h0000, 1, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 16'h0000);
    addVec(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, 5, 16'h0010, 1'b1, 1'b0, 16'h0010, 16'h0000);
    addVec(1'b1, 1'b0, 16'h001E, 2'b00, 16'h0000, 1, 16'h0017, 1'b0, 1'b0, 16'h0000, 16'h0000);
    addVec(1'b1, 1'b0, 16'h0090, 2'b00, 16'h0000, 5, 16'h0090, 1'b1, 1'b0, 16'h0090, 16'h0000);
    addVec(1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, 5, 16'h0010, 1'b1, 1'b0, 16'h0010, 16'h0000);
    addVec(1'b0, 1'b1, 16'h009A, 2'b11, 16'hD00D, 8, 16'h0000, 1'b1, 1'b1, 16'h0090, 16'hD00D);
    addVec(1'b1, 1'b0, 16'h009A, 2'b00, 16'h0000, 1, 16'hD00D, 1'b0, 1'b0, 16'h0000, 16'h0000);
    addVec(1'b1, 1'b0, 16'h0094, 2'b00, 16'h0000, 1, 16'h0092, 1'b0, 1'b0, 16'h0000, 16'h0000);
    addVec(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, 5, 16'hAAEF, 1'b1, 1'b0, 16'h1230, 16'h0000);
    addVec(1'b1, 1'b0, 16'h2340, 2'b00, 16'h0000, 5, 16'h2340, 1'b1, 1'b0, 16'h2340, 16'h0000);
    addVec(1'b1, 1'b0, 16'h009A, 2'b00, 16'h0000, 5, 16'hD00D, 1'b1, 1'b0, 16'h0090, 16'h0000);

    reset = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_mem_resp", 32'(mem_resp), 32'd0);
    checkOutput("reset_pmem_read", 32'(pmem_read), 32'd0);
    checkOutput("reset_pmem_write", 32'(pmem_write), 32'd0);
    checkOutput("reset_mem_rdata", 32'(mem_rdata), 32'd0);
`ifdef CACHE_STATS_EN
    checkOutput("reset_hit_count", 32'(hit_count), 32'd0);
    checkOutput("reset_miss_count", 32'(miss_count), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 17) resetDuringFill();
      applyStimulus(vecs[i], cyc, rdata, saw_rd, saw_wr, paddr, pline, both);
      checkOutput($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
      checkOutput($sformatf("v%0d_pmem_read", i), 32'(saw_rd), 32'(vecs[i].pread));
      checkOutput($sformatf("v%0d_pmem_write", i), 32'(saw_wr), 32'(vecs[i].pwrite));
      checkOutput($sformatf("v%0d_rd_wr_overlap", i), 32'(both), 32'd0);
      if (vecs[i].rd && !vecs[i].wr)
        checkOutput($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].rdata));
      if (vecs[i].pread || vecs[i].pwrite)
        checkOutput($sformatf("v%0d_paddr", i), 32'(paddr), 32'(vecs[i].paddr));
      if (vecs[i].pwrite) begin
        w = vecs[i].addr[3:1];
        checkOutput($sformatf("v%0d_pword", i), 32'(pline[{w, 4'b0000} +: 16]), 32'(vecs[i].pword));
      end
`ifdef CACHE_STATS_EN
      if (i == 3) begin
        checkOutput("stats_hit_count", 32'(hit_count), 32'd3);
        checkOutput("stats_miss_count", 32'(miss_count), 32'd1);
      end
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
